// File: rtl/dac_spi_tx_if.sv
// Fabric-side frame request channel for the DAC serialiser: one frame per valid/ready handshake.
interface dac_spi_tx_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PD_W   = 2;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [PD_W-1:0]   s_pd;

  modport master (output s_valid, output s_data, output s_pd, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_pd, output s_ready);
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises {6'b0, pd, data} into 24-bit SYNC/SCLK/DIN write frames for the board DAC.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         CLK_50_MAX10,
  input  logic         CPU_RESETn,
  dac_spi_tx_if.slave  s,
  output logic         DAC_SYNC,
  output logic         DAC_SCLK,
  output logic         DAC_DIN,
  output logic         done,
  output logic [15:0]  frame_cnt
);

  localparam int unsigned FRAME_W  = 24;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BIT_W    = 5;
  localparam int unsigned BIT_LAST = FRAME_W - 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DIV_LAST = CLK_DIV - 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ready_q, ready_d;
  logic               sync_q, sync_d;
  logic               sclk_q, sclk_d;
  logic               din_q, din_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0] frame_c;

  assign frame_c = {6'b0, s.s_pd, s.s_data};

  // State and output registers; reset drives SYNC high at once to abort any write in flight.
  always_ff @(posedge CLK_50_MAX10 or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      ready_q     <= 1'b1;
      sync_q      <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      ready_q     <= ready_d;
      sync_q      <= sync_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next state; sclk_q doubles as the phase flag (1 = high phase, 0 = low phase) in SHIFT.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    div_d       = div_q;
    gap_d       = gap_q;
    ready_d     = ready_q;
    sync_d      = sync_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (s.s_valid && ready_q) begin
          shreg_d = frame_c;
          bit_d   = BIT_W'(BIT_LAST);
          div_d   = '0;
          ready_d = 1'b0;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          din_d   = frame_c[FRAME_W-1];
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q == DIV_W'(DIV_LAST)) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == '0) begin
            sclk_d      = 1'b1;
            sync_d      = 1'b1;
            din_d       = 1'b0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            gap_d       = '0;
            if (GAP_CYCLES > 1) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              ready_d = 1'b1;
            end
          end else begin
            // Rotate so the next bit sits at [FRAME_W-2]; DIN only moves at the start of a high phase.
            sclk_d  = 1'b1;
            bit_d   = bit_q - BIT_W'(1);
            shreg_d = {shreg_q[FRAME_W-2:0], shreg_q[FRAME_W-1]};
            din_d   = shreg_q[FRAME_W-2];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      GAP: begin
        // Ready rises one cycle early so an accept lands exactly GAP_CYCLES after SYNC rises.
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign s.s_ready = ready_q;
  assign DAC_SYNC  = sync_q;
  assign DAC_SCLK  = sclk_q;
  assign DAC_DIN   = din_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serialises 16-bit samples plus a 2-bit power-down code into 24-bit write frames for the board's 16-bit serial DAC. It sits directly upstream of the `DAC_SYNC` / `DAC_SCLK` / `DAC_DIN` top-level pins and drives them unmodified. On the fabric side it accepts one frame per valid/ready handshake from the Nios II peripheral or a waveform generator. It also provides a completion pulse and a frame counter for software.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `CLK_50_MAX10` cycles; legal values ≥1. The default gives 12.5 MHz SCLK.
- `GAP_CYCLES`, default 2: minimum number of cycles `DAC_SYNC` stays high between frames; legal values ≥1.
- `CLK_50_MAX10` in 1: the block's only clock; all logic is on its rising edge.
- `CPU_RESETn` in 1: asynchronous, active-low reset.
- `s_valid` in 1: a frame request is present.
- `s_ready` out 1: the block can accept a frame; high only in IDLE.
- `s_data` in 16: DAC code, loaded into frame bits [15:0].
- `s_pd` in 2: power-down mode, loaded into frame bits [17:16]. Frame bits [23:18] are always 0.
- `DAC_SYNC` out 1: frame enable, active low.
- `DAC_SCLK` out 1: serial clock; idles high. The DAC samples `DAC_DIN` on the falling edge.
- `DAC_DIN` out 1: serial data, MSB first.
- `done` out 1: one-cycle pulse when a frame completes.
- `frame_cnt` out 16: count of completed frames; wraps modulo 2^16.

## Operation
- States:
  - IDLE
  - SHIFT
  - GAP
- Reset values (applied asynchronously while `CPU_RESETn`=0):
  - state=IDLE, `s_ready`=1, `DAC_SYNC`=1, `DAC_SCLK`=1, `DAC_DIN`=0, `done`=0, `frame_cnt`=0.
  - The shift register, bit counter and divider counter clear to 0.
- IDLE:
  - A transfer is accepted on a rising edge with `s_valid`=1 and `s_ready`=1.
  - The frame {6'b0, `s_pd`, `s_data`} is latched into the 24-bit shift register. Later changes on the inputs have no effect.
  - Next state: SHIFT.
  - With `s_valid`=0, the block stays in IDLE and all outputs hold their idle values.
- SHIFT:
  - 24 bits are sent, each lasting 2·`CLK_DIV` cycles.
  - Each bit has a high phase of `CLK_DIV` cycles with `DAC_SCLK`=1, then a low phase of `CLK_DIV` cycles with `DAC_SCLK`=0.
  - `DAC_DIN` changes only at the start of a high phase, which gives `CLK_DIV` cycles of setup before the falling edge.
  - A 5-bit bit counter counts 23 down to 0; the divider counter counts 0 to `CLK_DIV`-1.
  - After the low phase of bit 0: `DAC_SCLK`=1, `DAC_SYNC`=1, `DAC_DIN`=0, `done`=1 for one cycle, `frame_cnt` increments. Next state: GAP.
- GAP:
  - `DAC_SYNC` is held high for `GAP_CYCLES` cycles, then the block enters IDLE with `s_ready`=1.
- `s_valid` has no effect outside IDLE. No frame is dropped or duplicated: exactly one frame is sent per handshake.
- `frame_cnt` wraps from 0xFFFF to 0x0000 with no flag.
- If reset asserts mid-frame, the frame is abandoned at once. `DAC_SYNC` rises asynchronously, which aborts the write at the DAC. No `done` pulse is produced and `frame_cnt` clears.
- All outputs are registered; no combinational path runs from the inputs to the pins.

## Timing
- Let T0 be the accepting rising edge.
  - From T0 to T0+1: `DAC_SYNC`=0, `DAC_SCLK`=1, `DAC_DIN`=frame[23], `s_ready`=0.
  - `DAC_SYNC` stays low for exactly 48·`CLK_DIV` cycles (96 at the default).
- At T0+48·`CLK_DIV`: `DAC_SYNC`=1 and `done`=1 (for that single cycle).
- `s_ready`=1 at T0+48·`CLK_DIV`+`GAP_CYCLES`.
  - If `s_valid` is held high, the next accept occurs on that same edge.
  - Frame period = 48·`CLK_DIV`+`GAP_CYCLES` cycles (98 at the defaults).
- Falling SCLK edge k (k=1..24) occurs at T0+(2k−1)·`CLK_DIV`.
- After reset deasserts, `s_ready`=1 and a frame can be accepted on the first rising edge.

## Test plan
- Single frame, `s_data`=0xA5C3, `s_pd`=2'b00:
  - Sampling `DAC_DIN` on the 24 `DAC_SCLK` falling edges gives 24'h00A5C3.
  - `DAC_SYNC` is low for 96 cycles, then `done` pulses once and `frame_cnt`=1.
- `s_pd`=2'b11, `s_data`=0xFFFF → the captured frame is 24'h03FFFF, and bits [23:18] are 0.
- `s_valid` held high with data 0x0001, 0x8000, 0x1234 → three frames on consecutive accepts exactly 98 cycles apart, captured in order, each with exactly 24 falling edges and `frame_cnt`=3.
- `CLK_DIV`=1, `GAP_CYCLES`=1:
  - SCLK toggles every cycle and `DAC_SYNC` is low for 48 cycles, frame period 49 cycles.
  - `DAC_DIN` is stable for ≥1 cycle before every falling edge.
- `CPU_RESETn` pulsed low at cycle 40 of a frame:
  - `DAC_SYNC`=1, `DAC_SCLK`=1 and `DAC_DIN`=0 immediately, with no `done` pulse and `frame_cnt`=0.
  - `s_ready`=1 after release, and the next frame is sent intact.
- Counter wrap: `frame_cnt` forced (or run) to 0xFFFF, then one frame → `frame_cnt`=0x0000 and `done`=1.
